// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and decode: up to two pushes and two pops per cycle,
// first-word fall-through on the two head entries, flush on redirect.
module inst_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       write_en1,
    input  logic                       write_en2,
    input  logic [31:0]                write_pc1,
    input  logic [31:0]                write_pc2,
    input  logic [31:0]                write_inst1,
    input  logic [31:0]                write_inst2,
    input  logic [2:0]                 write_flags1,
    input  logic [2:0]                 write_flags2,
    input  logic                       read_en1,
    input  logic                       read_en2,
    output logic                       inst1_valid,
    output logic                       inst2_valid,
    output logic [31:0]                inst1_pc,
    output logic [31:0]                inst1_inst,
    output logic [2:0]                 inst1_flags,
    output logic [31:0]                inst2_pc,
    output logic [31:0]                inst2_inst,
    output logic [2:0]                 inst2_flags,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH):0]     o_dbg_count,
    output logic [$clog2(DEPTH)-1:0]   o_dbg_rptr,
    output logic [$clog2(DEPTH)-1:0]   o_dbg_wptr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a slot is pushed when its write_en is high and space remains at the start of
    // the cycle; a head entry is consumed when its read_en is high and the matching valid is 1.

    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_inst  [DEPTH];
    logic [2:0]    r_flags [DEPTH];
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wptr;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_free;
    logic [CW-1:0] w_nw_req;
    logic [CW-1:0] w_nr_req;
    logic [CW-1:0] w_nw;
    logic [CW-1:0] w_nr;
    logic [AW-1:0] w_rptr1;
    logic [AW-1:0] w_wptr1;

    always_comb begin
        w_free   = CW'(DEPTH) - r_count;
        w_nw_req = write_en1 ? (write_en2 ? CW'(2) : CW'(1)) : CW'(0);
        w_nr_req = read_en1  ? (read_en2  ? CW'(2) : CW'(1)) : CW'(0);
        // Space is judged before this cycle's pops; slot 2 is the first to be dropped.
        w_nw     = (w_nw_req > w_free)  ? w_free  : w_nw_req;
        w_nr     = (w_nr_req > r_count) ? r_count : w_nr_req;
        w_rptr1  = r_rptr + AW'(1);
        w_wptr1  = r_wptr + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (!flush && w_nw >= CW'(1)) begin
            r_pc[r_wptr]    <= write_pc1;
            r_inst[r_wptr]  <= write_inst1;
            r_flags[r_wptr] <= write_flags1;
        end
        if (!flush && w_nw == CW'(2)) begin
            r_pc[w_wptr1]    <= write_pc2;
            r_inst[w_wptr1]  <= write_inst2;
            r_flags[w_wptr1] <= write_flags2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_rptr  <= r_rptr + w_nr[AW-1:0];
            r_wptr  <= r_wptr + w_nw[AW-1:0];
            r_count <= r_count + w_nw - w_nr;
        end
    end

    always_comb begin
        inst1_valid = (r_count >= CW'(1));
        inst2_valid = (r_count >= CW'(2));
        fifo_empty  = (r_count == '0);
        fifo_full   = (r_count >= CW'(DEPTH - 1));
        inst1_pc    = r_pc[r_rptr];
        inst1_inst  = r_inst[r_rptr];
        inst1_flags = r_flags[r_rptr];
        inst2_pc    = r_pc[w_rptr1];
        inst2_inst  = r_inst[w_rptr1];
        inst2_flags = r_flags[w_rptr1];
        o_dbg_count = r_count;
        o_dbg_rptr  = r_rptr;
        o_dbg_wptr  = r_wptr;
    end
endmodule

// File: tb/tb_inst_fifo.sv
// Scoreboarded bench for inst_fifo: a queue model of accepted entries is checked against the
// head outputs and status flags every cycle.
module tb_inst_fifo;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic clk, rst, flush;
  logic write_en1, write_en2, read_en1, read_en2;
  logic [31:0] write_pc1, write_pc2, write_inst1, write_inst2;
  logic [2:0] write_flags1, write_flags2;
  logic inst1_valid, inst2_valid, fifo_full, fifo_empty;
  logic [31:0] inst1_pc, inst1_inst, inst2_pc, inst2_inst;
  logic [2:0] inst1_flags, inst2_flags;
  logic [AW:0] o_dbg_count;
  logic [AW-1:0] o_dbg_rptr, o_dbg_wptr;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_pc1(write_pc1), .write_pc2(write_pc2),
    .write_inst1(write_inst1), .write_inst2(write_inst2),
    .write_flags1(write_flags1), .write_flags2(write_flags2),
    .read_en1(read_en1), .read_en2(read_en2),
    .inst1_valid(inst1_valid), .inst2_valid(inst2_valid),
    .inst1_pc(inst1_pc), .inst1_inst(inst1_inst), .inst1_flags(inst1_flags),
    .inst2_pc(inst2_pc), .inst2_inst(inst2_inst), .inst2_flags(inst2_flags),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .o_dbg_count(o_dbg_count), .o_dbg_rptr(o_dbg_rptr), .o_dbg_wptr(o_dbg_wptr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state: entry = {pc, inst, flags}
  logic [66:0] exp_q[$];
  int m_rptr, m_wptr;
  logic [31:0] next_pc;
  logic use_tag;
  logic [2:0] tag_flags;
  int n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check("count", 32'(o_dbg_count), 32'(sz));
    check("v1", 32'(inst1_valid), 32'(sz >= 1));
    check("v2", 32'(inst2_valid), 32'(sz >= 2));
    check("empty", 32'(fifo_empty), 32'(sz == 0));
    check("full", 32'(fifo_full), 32'(sz >= DEPTH - 1));
    check("rptr", 32'(o_dbg_rptr), 32'(m_rptr));
    check("wptr", 32'(o_dbg_wptr), 32'(m_wptr));
    if (sz >= 1) begin
      check("pc1", inst1_pc, exp_q[0][66:35]);
      check("inst1", inst1_inst, exp_q[0][34:3]);
      check("flags1", 32'(inst1_flags), 32'(exp_q[0][2:0]));
    end
    if (sz >= 2) begin
      check("pc2", inst2_pc, exp_q[1][66:35]);
      check("inst2", inst2_inst, exp_q[1][34:3]);
      check("flags2", 32'(inst2_flags), 32'(exp_q[1][2:0]));
    end
  endtask

  // driver: one clock cycle of stimulus with model update
  task automatic step(input logic we1, input logic we2, input logic re1, input logic re2,
                      input logic fl);
    int sz, nw, nr;
    write_en1 = we1; write_en2 = we2; read_en1 = re1; read_en2 = re2; flush = fl;
    write_pc1 = next_pc;
    write_pc2 = next_pc + 32'd4;
    write_inst1 = $urandom;
    write_inst2 = $urandom;
    write_flags1 = use_tag ? tag_flags : 3'($urandom_range(0, 7));
    write_flags2 = 3'($urandom_range(0, 7));
    check_outputs();
    sz = exp_q.size();
    if (fl) begin
      exp_q.delete();
      m_rptr = 0;
      m_wptr = 0;
    end else begin
      nr = re1 ? (re2 ? 2 : 1) : 0;
      if (nr > sz) nr = sz;
      for (int i = 0; i < nr; i++) void'(exp_q.pop_front());
      m_rptr = (m_rptr + nr) % DEPTH;
      nw = we1 ? (we2 ? 2 : 1) : 0;
      if (nw > DEPTH - sz) nw = DEPTH - sz;
      if (nw >= 1) exp_q.push_back({write_pc1, write_inst1, write_flags1});
      if (nw == 2) exp_q.push_back({write_pc2, write_inst2, write_flags2});
      m_wptr = (m_wptr + nw) % DEPTH;
      next_pc = next_pc + 32'(4 * nw);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH && exp_q.size() > 0; i++) step(0, 0, 1, 1, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_rptr = 0; m_wptr = 0;
    use_tag = 1'b0; tag_flags = 3'b000;
    rst = 1'b0; flush = 1'b0;
    write_en1 = 0; write_en2 = 0; read_en1 = 0; read_en2 = 0;
    write_pc1 = '0; write_pc2 = '0; write_inst1 = '0; write_inst2 = '0;
    write_flags1 = '0; write_flags2 = '0;
    next_pc = 32'hbfc00000;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    // first dual push after reset
    step(1, 1, 0, 0, 0);
    check("r30_pc1", inst1_pc, 32'hbfc00000);
    check("r30_pc2", inst2_pc, 32'hbfc00004);
    check("r30_cnt", 32'(o_dbg_count), 32'd2);
    drain();

    // fill to full, then overflow attempt
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0);
    check("r31_cnt14", 32'(o_dbg_count), 32'd14);
    check("r31_full0", 32'(fifo_full), 32'd0);
    step(1, 1, 0, 0, 0);
    check("r31_full1", 32'(fifo_full), 32'd1);
    step(1, 1, 0, 0, 0);
    check("r31_cnt16", 32'(o_dbg_count), 32'd16);
    drain();

    // count 15 plus dual push: only slot 1 fits
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("r32_cnt16", 32'(o_dbg_count), 32'd16);
    drain();

    // steady dual push + dual pop with pointer wrap
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() >= 1) check("r33_seq", inst2_pc, inst1_pc + 32'd4);
      step(1, 1, 1, 1, 0);
    end
    check("r33_cnt", 32'(o_dbg_count), 32'd6);
    drain();

    // dual pop with one entry
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    check("r34_empty", 32'(fifo_empty), 32'd1);
    step(0, 0, 1, 1, 0);

    // flush with push and pop, then tagged push
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("r35_cnt9", 32'(o_dbg_count), 32'd9);
    step(1, 1, 1, 1, 1);
    check("r35_v1", 32'(inst1_valid), 32'd0);
    next_pc = 32'h80000180;
    use_tag = 1'b1; tag_flags = 3'b100;
    step(1, 0, 0, 0, 0);
    use_tag = 1'b0;
    check("r35_pc", inst1_pc, 32'h80000180);
    check("r35_flags", 32'(inst1_flags), 32'd4);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    rst = 1'b0;
    #1;
    exp_q.delete();
    m_rptr = 0; m_wptr = 0;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 1, 0, 0, 0);
    check("rst_push", 32'(o_dbg_count), 32'd2);
    drain();
    step(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
